// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: handshaked inter-stage payload buffer.
// SKID=1 gives a 2-entry skid with registered in_ready; SKID=0 a single register.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } state_t;

      state_t            state;
      state_t            state_nxt;
      logic [DATA_W-1:0] head;
      logic [DATA_W-1:0] skid;
      logic              rdy_q;
      logic              head_we;
      logic              head_from_skid;
      logic              skid_we;
      logic              in_fire;
      logic              out_fire;

      assign in_fire  = in_valid & rdy_q;
      assign out_fire = (state != EMPTY) & out_ready;

      // next occupancy and payload write enables; flush wins
      always_comb begin
        state_nxt      = state;
        head_we        = 1'b0;
        head_from_skid = 1'b0;
        skid_we        = 1'b0;
        if (flush) begin
          state_nxt = EMPTY;
        end else begin
          unique case (state)
            EMPTY: begin
              if (in_fire) begin
                state_nxt = ONE;
                head_we   = 1'b1;
              end
            end
            ONE: begin
              if (in_fire && out_fire) begin
                head_we = 1'b1;
              end else if (in_fire) begin
                state_nxt = TWO;
                skid_we   = 1'b1;
              end else if (out_fire) begin
                state_nxt = EMPTY;
              end
            end
            TWO: begin
              if (out_fire) begin
                state_nxt      = ONE;
                head_we        = 1'b1;
                head_from_skid = 1'b1;
              end
            end
            default: state_nxt = EMPTY;
          endcase
        end
      end

      // state register; in_ready registered from the next state
      always_ff @(posedge clk) begin
        if (rst) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else begin
          state <= state_nxt;
          rdy_q <= (state_nxt != TWO);
        end
      end

      // payload entries load only on their write enables
      always_ff @(posedge clk) begin
        if (rst) begin
          head <= '0;
          skid <= '0;
        end else begin
          if (head_we) head <= head_from_skid ? skid : in_data;
          if (skid_we) skid <= in_data;
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state != EMPTY);
      assign out_data  = head;
      assign occupancy = state;
    end else begin : g_reg
      logic              v_q;
      logic [DATA_W-1:0] d_q;
      logic              rdy;
      logic              in_fire;

      assign rdy     = ~v_q | out_ready;
      assign in_fire = in_valid & rdy;

      // single-entry register with pass-through ready
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (flush) begin
          v_q <= 1'b0;
        end else if (in_fire) begin
          v_q <= 1'b1;
          d_q <= in_data;
        end else if (v_q && out_ready) begin
          v_q <= 1'b0;
        end
      end

      assign in_ready  = rdy;
      assign out_valid = v_q;
      assign out_data  = d_q;
      assign occupancy = {1'b0, v_q};
    end
  endgenerate

  // saturating count of cycles the head waits on downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: queue model plus directed vectors for
// a skid instance (CNT_W=3) and a single-register instance.
module tb_pipe_stage_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_occ;
  logic [2:0] a_stall;

  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_occ;
  logic [15:0] b_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(8), .SKID(1), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_buf #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // model: FIFO list of held payloads per instance
  int         mn[2];
  logic [7:0] mb[2][2];
  logic [7:0] mlast[2];
  int         mst[2];
  int         mcap[2] = '{2, 1};
  int         mmax[2] = '{7, 65535};
  bit         started = 1'b0;

  function automatic logic exp_rdy(input int i);
    if (i == 0) return mn[0] < 2;
    return (mn[1] == 0) || out_ready;
  endfunction

  task automatic cmp_inst(input int i, input string p, input logic v,
                          input logic r, input logic [7:0] d,
                          input logic [1:0] o, input int s);
    chk({p, ".valid"}, 32'(v), 32'(mn[i] != 0));
    chk({p, ".ready"}, 32'(r), 32'(exp_rdy(i)));
    chk({p, ".occ"}, 32'(o), 32'(mn[i]));
    chk({p, ".data"}, 32'(d), 32'(mn[i] != 0 ? mb[i][0] : mlast[i]));
    chk({p, ".stall"}, 32'(s), 32'(mst[i]));
  endtask

  task automatic upd(input int i);
    logic ov, ofire, ifire;
    if (rst) begin
      mn[i] = 0; mst[i] = 0; mlast[i] = 8'h00;
      return;
    end
    ov    = (mn[i] != 0);
    ofire = ov && out_ready;
    ifire = in_valid && exp_rdy(i);
    if (ov) mlast[i] = mb[i][0];
    if (ov && !out_ready && mst[i] < mmax[i]) mst[i]++;
    if (flush) begin
      mn[i] = 0;
      return;
    end
    if (ofire) begin
      mb[i][0] = mb[i][1];
      mn[i]--;
    end
    if (ifire && mn[i] < mcap[i]) begin
      mb[i][mn[i]] = in_data;
      mn[i]++;
    end
  endtask

  // per-cycle compare against the model, then advance it
  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, "a", a_out_valid, a_in_ready, a_out_data, a_occ,
               int'(a_stall));
      cmp_inst(1, "b", b_out_valid, b_in_ready, b_out_data, b_occ,
               int'(b_stall));
    end
    upd(0);
    upd(1);
    if (rst) started = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid", 32'(a_out_valid), 32'd0);
    chk("rst.occ", 32'(a_occ), 32'd0);
    chk("rst.stall", 32'(a_stall), 32'd0);
    chk("rst.ready", 32'(a_in_ready), 32'd1);

    // streaming
    step();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    step(); in_data = 8'h22;
    @(negedge clk);
    chk("str.d0", 32'(a_out_data), 32'h11);
    chk("str.occ", 32'(a_occ), 32'd1);
    step(); in_data = 8'h33;
    @(negedge clk);
    chk("str.d1", 32'(a_out_data), 32'h22);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("str.d2", 32'(a_out_data), 32'h33);
    chk("str.b_d2", 32'(b_out_data), 32'h33);
    step();
    @(negedge clk);
    chk("str.stall", 32'(a_stall), 32'd0);

    // backpressure
    step(); do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    step(); in_data = 8'h0B;
    step(); in_data = 8'h0C;
    @(negedge clk);
    chk("bp.occ", 32'(a_occ), 32'd2);
    chk("bp.ready", 32'(a_in_ready), 32'd0);
    chk("bp.stall1", 32'(a_stall), 32'd1);
    step();
    @(negedge clk);
    chk("bp.stall2", 32'(a_stall), 32'd2);
    chk("bp.hold", 32'(a_out_data), 32'h0A);
    step(); out_ready = 1'b1;
    @(negedge clk);
    chk("bp.o0", 32'(a_out_data), 32'h0A);
    step();
    @(negedge clk);
    chk("bp.o1", 32'(a_out_data), 32'h0B);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp.o2", 32'(a_out_data), 32'h0C);
    chk("bp.stall3", 32'(a_stall), 32'd3);
    step();

    // flush while full
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    step(); in_data = 8'h02;
    step(); flush = 1'b1; in_data = 8'h0D;
    @(negedge clk);
    chk("fl.full", 32'(a_occ), 32'd2);
    step(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl.occ", 32'(a_occ), 32'd0);
    chk("fl.valid", 32'(a_out_valid), 32'd0);
    chk("fl.ready", 32'(a_in_ready), 32'd1);
    chk("fl.data", 32'(a_out_data), 32'h01);
    chk("fl.b_valid", 32'(b_out_valid), 32'd0);
    // flush dropping an accepted input while head is consumed
    step(); in_valid = 1'b1; in_data = 8'h21; out_ready = 1'b1;
    step(); in_data = 8'h0E; flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl2.valid", 32'(a_out_valid), 32'd0);
    step();

    // single-register simultaneous fire
    do_reset();
    in_valid = 1'b1; in_data = 8'h05;
    step(); in_data = 8'h06; out_ready = 1'b1;
    @(negedge clk);
    chk("s0.ready", 32'(b_in_ready), 32'd1);
    chk("s0.d5", 32'(b_out_data), 32'h05);
    step(); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("s0.d6", 32'(b_out_data), 32'h06);
    chk("s0.valid", 32'(b_out_valid), 32'd1);
    step();

    // mixed pattern
    do_reset();
    for (int i = 0; i < 40; i++) begin
      in_valid  = (i % 4) != 3;
      in_data   = 8'(i * 7 + 1);
      out_ready = (i % 3) != 0;
      flush     = (i == 25);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // counter saturation
    do_reset();
    in_valid = 1'b1; in_data = 8'h77;
    step(); in_valid = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("sat.a", 32'(a_stall), 32'd7);
    chk("sat.b", 32'(b_stall), 32'd10);
    step();
    @(negedge clk);
    chk("sat.hold", 32'(a_stall), 32'd7);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("sat.clr", 32'(a_stall), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
